// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter feeding the physical register file: per-source FIFOs, round-robin
// selection of up to NUM_WRITE distinct-address heads per cycle onto registered write ports.
module regfile_write_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SIZE      = 64,
    parameter int unsigned NUM_SRC   = 6,
    parameter int unsigned NUM_WRITE = 4,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0]                  IN_valid,
    output logic [NUM_SRC-1:0]                  OUT_ready,
    input  logic [NUM_SRC*$clog2(SIZE)-1:0]     IN_waddr,
    input  logic [NUM_SRC*WIDTH-1:0]            IN_wdata,
    output logic [NUM_WRITE-1:0]                OUT_we,
    output logic [NUM_WRITE*$clog2(SIZE)-1:0]   OUT_waddr,
    output logic [NUM_WRITE*WIDTH-1:0]          OUT_wdata,
    output logic                                OUT_idle
);

    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [AW-1:0]    mem_addr [NUM_SRC][QDEPTH];
    logic [WIDTH-1:0] mem_data [NUM_SRC][QDEPTH];
    logic [PW-1:0]    rd_q [NUM_SRC];
    logic [PW-1:0]    wr_q [NUM_SRC];
    logic [CW-1:0]    cnt_q [NUM_SRC];
    logic [CW-1:0]    cnt_d [NUM_SRC];
    logic [RW-1:0]    rr_q, rr_d;

    logic [AW-1:0]    head_addr [NUM_SRC];
    logic [WIDTH-1:0] head_data [NUM_SRC];
    logic [NUM_SRC-1:0] nonempty, enq, deq;

    logic [NUM_WRITE-1:0] we_d, we_q;
    logic [AW-1:0]        port_addr [NUM_WRITE];
    logic [WIDTH-1:0]     port_data [NUM_WRITE];
    logic [NUM_WRITE*AW-1:0]    waddr_q;
    logic [NUM_WRITE*WIDTH-1:0] wdata_q;
    logic idle_d, idle_q;

    // Ready comes from registered occupancy only, gated by reset.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            head_addr[k] = mem_addr[k][rd_q[k]];
            head_data[k] = mem_data[k][rd_q[k]];
            nonempty[k]  = (cnt_q[k] != '0);
            OUT_ready[k] = rst_n && (cnt_q[k] < FULL);
            enq[k]       = IN_valid[k] && OUT_ready[k];
        end
    end

    // Round-robin scan from rr; zero-register heads drain without consuming a port.
    always_comb begin
        int unsigned src;
        int unsigned ngrant;
        logic        clash;
        deq    = '0;
        we_d   = '0;
        rr_d   = rr_q;
        ngrant = 0;
        src    = 0;
        clash  = 1'b0;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            port_addr[j] = '0;
            port_data[j] = '0;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src = 32'(rr_q) + i;
            if (src >= NUM_SRC) src = src - NUM_SRC;
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (k == src && nonempty[k]) begin
                    if (head_addr[k] == '0) begin
                        deq[k] = 1'b1;
                    end else if (ngrant < NUM_WRITE) begin
                        clash = 1'b0;
                        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                            if (j < ngrant && port_addr[j] == head_addr[k]) clash = 1'b1;
                        end
                        if (!clash) begin
                            for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                                if (j == ngrant) begin
                                    we_d[j]      = 1'b1;
                                    port_addr[j] = head_addr[k];
                                    port_data[j] = head_data[k];
                                end
                            end
                            deq[k] = 1'b1;
                            ngrant = ngrant + 1;
                            rr_d   = (k + 1 == NUM_SRC) ? '0 : RW'(k + 1);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        idle_d = (we_d == '0);
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cnt_d[k] = cnt_q[k];
            if (enq[k] && !deq[k]) cnt_d[k] = cnt_q[k] + CW'(1);
            else if (!enq[k] && deq[k]) cnt_d[k] = cnt_q[k] - CW'(1);
            if (cnt_d[k] != '0) idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                rd_q[k]  <= '0;
                wr_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
            rr_q    <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            idle_q  <= 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= cnt_d[k];
                if (enq[k]) wr_q[k] <= wr_q[k] + PW'(1);
                if (deq[k]) rd_q[k] <= rd_q[k] + PW'(1);
            end
            for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                waddr_q[j*AW +: AW]       <= port_addr[j];
                wdata_q[j*WIDTH +: WIDTH] <= port_data[j];
            end
            rr_q   <= rr_d;
            we_q   <= we_d;
            idle_q <= idle_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (enq[k]) begin
                mem_addr[k][wr_q[k]] <= IN_waddr[k*AW +: AW];
                mem_data[k][wr_q[k]] <= IN_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign OUT_we    = we_q;
    assign OUT_waddr = waddr_q;
    assign OUT_wdata = wdata_q;
    assign OUT_idle  = idle_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_regfile_write_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned SZ = 64;
    localparam int unsigned NS = 6;
    localparam int unsigned NW = 4;
    localparam int unsigned QD = 2;
    localparam int unsigned AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NS-1:0]    IN_valid = '0;
    logic [NS-1:0]    OUT_ready;
    logic [NS*AW-1:0] IN_waddr = '0;
    logic [NS*W-1:0]  IN_wdata = '0;
    logic [NW-1:0]    OUT_we;
    logic [NW*AW-1:0] OUT_waddr;
    logic [NW*W-1:0]  OUT_wdata;
    logic             OUT_idle;

    regfile_write_arbiter #(
        .WIDTH(W), .SIZE(SZ), .NUM_SRC(NS), .NUM_WRITE(NW), .QDEPTH(QD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .IN_valid(IN_valid), .OUT_ready(OUT_ready),
        .IN_waddr(IN_waddr), .IN_wdata(IN_wdata),
        .OUT_we(OUT_we), .OUT_waddr(OUT_waddr), .OUT_wdata(OUT_wdata),
        .OUT_idle(OUT_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } ent_t;

    // Reference model state
    ent_t            mq [NS][$];
    int              m_rr;
    logic [NW-1:0]   exp_we;
    logic [NW*AW-1:0] exp_waddr;
    logic [NW*W-1:0] exp_wdata;
    logic            exp_idle;
    int              acc_cnt [NS];
    bit              bp_phase = 1'b0;
    int              gap0, max_gap0;
    bit              saw_full0;
    bit              m_acc [NS];
    logic [AW-1:0]   m_used [NW];
    int              m_ng, m_last, m_s;
    bit              m_clash, m_had0, m_g0;
    ent_t            m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) mq[k].delete();
            m_rr = 0;
            exp_we = '0; exp_waddr = '0; exp_wdata = '0; exp_idle = 1'b1;
            gap0 = 0; max_gap0 = 0; saw_full0 = 1'b0;
        end else begin
            for (int k = 0; k < NS; k++) m_acc[k] = IN_valid[k] && (mq[k].size() < QD);
            m_had0 = (mq[0].size() > 0) && (mq[0][0].a != '0);
            m_ng = 0; m_last = 0; m_g0 = 1'b0;
            exp_we = '0; exp_waddr = '0; exp_wdata = '0;
            for (int i = 0; i < NS; i++) begin
                m_s = (m_rr + i) % NS;
                if (mq[m_s].size() > 0) begin
                    m_e = mq[m_s][0];
                    if (m_e.a == '0) begin
                        void'(mq[m_s].pop_front());
                    end else if (m_ng < NW) begin
                        m_clash = 1'b0;
                        for (int j = 0; j < m_ng; j++) if (m_used[j] == m_e.a) m_clash = 1'b1;
                        if (!m_clash) begin
                            m_used[m_ng] = m_e.a;
                            exp_we[m_ng] = 1'b1;
                            exp_waddr[m_ng*AW +: AW] = m_e.a;
                            exp_wdata[m_ng*W +: W]   = m_e.d;
                            void'(mq[m_s].pop_front());
                            m_ng++;
                            m_last = m_s;
                            if (m_s == 0) m_g0 = 1'b1;
                        end
                    end
                end
            end
            if (m_ng > 0) m_rr = (m_last + 1) % NS;
            for (int k = 0; k < NS; k++) begin
                if (m_acc[k]) begin
                    mq[k].push_back({IN_waddr[k*AW +: AW], IN_wdata[k*W +: W]});
                    acc_cnt[k]++;
                end
            end
            exp_idle = (m_ng == 0);
            for (int k = 0; k < NS; k++) if (mq[k].size() != 0) exp_idle = 1'b0;
            if (bp_phase) begin
                if (m_had0 && !m_g0) gap0++;
                else gap0 = 0;
                if (gap0 > max_gap0) max_gap0 = gap0;
                if (mq[0].size() == QD) saw_full0 = 1'b1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [NS-1:0] exp_rdy;
        int dup;
        for (int k = 0; k < NS; k++) exp_rdy[k] = rst_n && (mq[k].size() < QD);
        dup = 0;
        for (int a = 0; a < NW; a++)
            for (int b = a + 1; b < NW; b++)
                if (OUT_we[a] && OUT_we[b] && OUT_waddr[a*AW +: AW] == OUT_waddr[b*AW +: AW])
                    dup++;
        check("model_we", OUT_we, exp_we);
        check("model_waddr", OUT_waddr, exp_waddr);
        check("model_wdata", OUT_wdata, exp_wdata);
        check("model_ready", OUT_ready, exp_rdy);
        check("model_idle", OUT_idle, exp_idle);
        check("unique_waddr", dup, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_cycle();
    endtask

    task automatic set_src(input int k, input logic [AW-1:0] a, input logic [W-1:0] d);
        IN_valid[k] = 1'b1;
        IN_waddr[k*AW +: AW] = a;
        IN_wdata[k*W +: W] = d;
    endtask

    task automatic clr();
        IN_valid = '0;
    endtask

    initial begin
        int n;
        repeat (3) step();
        check("reset_we", OUT_we, 0);
        check("reset_ready", OUT_ready, 0);
        check("reset_idle", OUT_idle, 1);
        rst_n = 1'b1;

        // Overload: six distinct addresses, four ports.
        for (int k = 0; k < NS; k++) set_src(k, AW'(k + 1), 32'h100 + k);
        step();
        clr();
        step();
        check("ovl_we1", OUT_we, 4'b1111);
        check("ovl_addr1", OUT_waddr, {6'd4, 6'd3, 6'd2, 6'd1});
        check("ovl_data1", OUT_wdata, {32'h103, 32'h102, 32'h101, 32'h100});
        step();
        check("ovl_we2", OUT_we, 4'b0011);
        check("ovl_addr2", OUT_waddr, {6'd0, 6'd0, 6'd6, 6'd5});
        step();
        check("ovl_idle", OUT_idle, 1);

        // Single write from source 2.
        set_src(2, 6'd5, 32'hDEADBEEF);
        step();
        clr();
        check("single_busy", OUT_idle, 0);
        step();
        check("single_we", OUT_we, 4'b0001);
        check("single_addr", OUT_waddr[AW-1:0], 6'd5);
        check("single_data", OUT_wdata[W-1:0], 32'hDEADBEEF);
        step();
        check("single_we_off", OUT_we, 0);
        check("single_idle", OUT_idle, 1);

        // Same-address conflict between sources 0 and 1.
        set_src(0, 6'd9, 32'hAAAA0000);
        set_src(1, 6'd9, 32'hBBBB1111);
        step();
        clr();
        step();
        check("conf_we1", OUT_we, 4'b0001);
        check("conf_data1", OUT_wdata[W-1:0], 32'hAAAA0000);
        step();
        check("conf_we2", OUT_we, 4'b0001);
        check("conf_addr2", OUT_waddr[AW-1:0], 6'd9);
        check("conf_data2", OUT_wdata[W-1:0], 32'hBBBB1111);
        step();

        // Zero-register writes drain without using ports.
        for (int r = 0; r < 3; r++) begin
            set_src(3, 6'd0, 32'h5000 + r);
            step();
            check("zero_ready3", OUT_ready[3], 1);
            check("zero_we", OUT_we, 0);
        end
        clr();
        step();
        check("zero_idle", OUT_idle, 1);

        // Backpressure: all sources saturating.
        bp_phase = 1'b1;
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < NS; k++)
                set_src(k, AW'(10 + k), {k[7:0], 24'(acc_cnt[k])});
            step();
        end
        clr();
        bp_phase = 1'b0;
        n = 0;
        while (!OUT_idle && n < 40) begin
            step();
            n++;
        end
        check("bp_drain_idle", OUT_idle, 1);
        check("bp_src0_gap_le1", (max_gap0 <= 1), 1);
        check("bp_src0_filled", saw_full0, 1);

        // Reset with entries still queued.
        for (int k = 0; k < 4; k++) set_src(k, 6'd7, 32'h7000 + k);
        step();
        clr();
        step();
        check("rst_pre_we", OUT_we, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        check("rst_we", OUT_we, 0);
        check("rst_ready", OUT_ready, 0);
        check("rst_idle", OUT_idle, 1);
        step();
        step();
        rst_n = 1'b1;
        set_src(0, 6'd11, 32'h11111111);
        set_src(5, 6'd12, 32'h55555555);
        step();
        clr();
        step();
        check("post_rst_we", OUT_we, 4'b0011);
        check("post_rst_addr", OUT_waddr, {6'd0, 6'd0, 6'd12, 6'd11});
        step();
        check("post_rst_idle", OUT_idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
